// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL clock-lock monitor.
// Holds the monitor FSM state encoding and the synchronizer flush length.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    EVALUATE = 2'd2
  } lock_state_t;

  // Cycles spent in IDLE after reset so the synchronizer holds real samples.
  localparam int IDLE_CYCLES = 3;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/clock_lock_monitor_if.sv
// Result bundle of the clock-lock monitor.
// master drives the results; slave observes them.
interface clock_lock_monitor_if #(
  parameter int CNT_W = adpll_pkg::DEFAULT_CNT_W
);
  // count_valid_o is a one-cycle strobe with no back-pressure (no ready):
  // count_o is updated in the strobe cycle and holds until the next strobe,
  // and the flags/lock follow one cycle after the strobe.
  logic [CNT_W-1:0] count_o;
  logic             count_valid_o;
  logic             locked_o;
  logic             too_fast_o;
  logic             too_slow_o;

  modport master (
    output count_o,
    output count_valid_o,
    output locked_o,
    output too_fast_o,
    output too_slow_o
  );

  modport slave (
    input count_o,
    input count_valid_o,
    input locked_o,
    input too_fast_o,
    input too_slow_o
  );
endinterface

// File: rtl/clock_lock_monitor_edge_sync.sv
// edge_sync: 2-FF synchronizer followed by a registered rising-edge detect.
// Reusable for any asynchronous level input; reset is synchronous active-low.
module edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic rise_o
);
  // [0] and [1] form the synchronizer, [2] is the previous synchronized sample.
  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      rise_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_o <= sync_q[1] & ~sync_q[2];
    end
  end
endmodule

// File: rtl/clock_lock_monitor.sv
// Frequency lock monitor: counts fdiv_i rising edges per gate window and
// derives too-fast/too-slow/locked. Optional unlock hysteresis: LOCK_MON_HYST_EN.
module clock_lock_monitor
  import adpll_pkg::*;
#(
  parameter int GATE_CYCLES  = 5000,
  parameter int EXPECTED     = 1000,
  parameter int TOL          = 10,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic                 clk5_i,
  input  logic                 rst_n_i,
  input  logic                 fdiv_i,
  clock_lock_monitor_if.master mon,
  output lock_state_t          state_o
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_MAX = RUN_W'(LOCK_COUNT);
  // Lower bound clamps at zero when the tolerance exceeds the nominal count.
  localparam int LO_INT = (EXPECTED > TOL) ? (EXPECTED - TOL) : 0;
  localparam logic [CNT_W:0] LO_BOUND = (CNT_W + 1)'(LO_INT);
  localparam logic [CNT_W:0] HI_BOUND = (CNT_W + 1)'(EXPECTED + TOL);

  lock_state_t       state_q, state_d;
  logic              edge_det;
  logic              gate_last;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W:0]    edge_sum;
  logic [CNT_W-1:0]  edge_next;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              fast_q, slow_q, locked_q;
  logic              win_fast, win_slow, win_good;
  logic [RUN_W-1:0]  good_run_q, good_run_next;

`ifdef LOCK_MON_HYST_EN
  localparam int BAD_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [BAD_W-1:0] UNLOCK_MAX = BAD_W'(UNLOCK_COUNT);
  logic [BAD_W-1:0] bad_run_q, bad_run_next;
`endif

  edge_sync u_edge_sync (
    .clk_i   (clk5_i),
    .rst_n_i (rst_n_i),
    .async_i (fdiv_i),
    .rise_o  (edge_det)
  );

  // FSM state register
  always_ff @(posedge clk5_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state and decode
  always_comb begin
    state_d   = state_q;
    gate_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_cnt_q == IDLE_LAST) state_d = MEASURE;
      end
      MEASURE: begin
        if (gate_cnt_q == GATE_LAST) begin
          gate_last = 1'b1;
          state_d   = EVALUATE;
        end
      end
      EVALUATE: state_d = MEASURE;
      default:  state_d = IDLE;
    endcase
  end

  // Saturating edge accumulation and window classification
  always_comb begin
    edge_sum      = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, edge_det};
    edge_next     = edge_sum[CNT_W] ? {CNT_W{1'b1}} : edge_sum[CNT_W-1:0];
    win_fast      = (&count_q) || ({1'b0, count_q} > HI_BOUND);
    win_slow      = !win_fast && ({1'b0, count_q} < LO_BOUND);
    win_good      = !win_fast && !win_slow;
    good_run_next = (good_run_q == LOCK_MAX) ? good_run_q : good_run_q + RUN_W'(1);
`ifdef LOCK_MON_HYST_EN
    bad_run_next  = (bad_run_q == UNLOCK_MAX) ? bad_run_q : bad_run_q + BAD_W'(1);
`endif
  end

  always_ff @(posedge clk5_i) begin
    if (!rst_n_i) begin
      idle_cnt_q <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      fast_q     <= 1'b0;
      slow_q     <= 1'b0;
      locked_q   <= 1'b0;
      good_run_q <= '0;
`ifdef LOCK_MON_HYST_EN
      bad_run_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
        end
        MEASURE: begin
          edge_cnt_q <= edge_next;
          if (gate_last) begin
            gate_cnt_q <= '0;
            count_q    <= edge_next;
            valid_q    <= 1'b1;
          end else begin
            gate_cnt_q <= gate_cnt_q + GATE_W'(1);
          end
        end
        EVALUATE: begin
          // The edge seen during evaluation belongs to the next window.
          edge_cnt_q <= {{(CNT_W-1){1'b0}}, edge_det};
          fast_q     <= win_fast;
          slow_q     <= win_slow;
          if (win_good) begin
            good_run_q <= good_run_next;
            if (good_run_next == LOCK_MAX) locked_q <= 1'b1;
`ifdef LOCK_MON_HYST_EN
            bad_run_q <= '0;
`endif
          end else begin
            good_run_q <= '0;
`ifdef LOCK_MON_HYST_EN
            bad_run_q <= bad_run_next;
            if (bad_run_next == UNLOCK_MAX) locked_q <= 1'b0;
`else
            locked_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign mon.count_o       = count_q;
  assign mon.count_valid_o = valid_q;
  assign mon.too_fast_o    = fast_q;
  assign mon.too_slow_o    = slow_q;
  assign mon.locked_o      = locked_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_clock_lock_monitor.sv
// Directed bench for clock_lock_monitor with GATE_CYCLES=100, EXPECTED=20, TOL=1.
// Expectations follow LOCK_MON_HYST_EN when the bench is built with it.
module tb_clock_lock_monitor;
  import adpll_pkg::*;

  logic        clk5 = 1'b0;
  logic        rst_n = 1'b0;
  logic        fdiv;
  int          fdiv_period = 5;
  logic        fdiv_hold = 1'b1;
  lock_state_t dbg_state;
  int          checks = 0;
  int          errors = 0;
  int          lat;

  clock_lock_monitor_if #(.CNT_W(16)) mon_if ();

  clock_lock_monitor #(
    .GATE_CYCLES  (100),
    .EXPECTED     (20),
    .TOL          (1),
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (2),
    .CNT_W        (16)
  ) dut (
    .clk5_i  (clk5),
    .rst_n_i (rst_n),
    .fdiv_i  (fdiv),
    .mon     (mon_if.master),
    .state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk5 = ~clk5;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // fdiv source: period in clk5 cycles, new period taken at each rising edge; 0 holds a level
  initial begin
    fdiv = 1'b0;
    forever begin
      int p;
      p = fdiv_period;
      if (p == 0) begin
        fdiv = fdiv_hold;
        @(negedge clk5);
      end else begin
        fdiv = 1'b1;
        repeat (p / 2) @(negedge clk5);
        fdiv = 1'b0;
        repeat (p - p / 2) @(negedge clk5);
      end
    end
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clk5);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert ((obs >= lo) && (obs <= hi))
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Ticks until count_valid_o is seen; n is the number of ticks taken.
  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((mon_if.count_valid_o !== 1'b1) && (n < max_cycles));
  endtask

  task automatic check_flags(input string tag, input logic exp_fast,
                             input logic exp_slow, input logic exp_locked);
    check_eq({tag, " too_fast"}, 32'(mon_if.too_fast_o), 32'(exp_fast));
    check_eq({tag, " too_slow"}, 32'(mon_if.too_slow_o), 32'(exp_slow));
    check_eq({tag, " locked"},   32'(mon_if.locked_o),   32'(exp_locked));
  endtask

  // Starts one cycle after a strobe, ends one cycle after the next strobe.
  task automatic run_window(input string tag, input int lo, input int hi,
                            input logic exp_fast, input logic exp_slow,
                            input logic exp_locked_pre, input logic exp_locked);
    int n;
    wait_valid(250, n);
    check_eq({tag, " latency"}, n, 100);
    check_range({tag, " count"}, 32'(mon_if.count_o), lo, hi);
    check_eq({tag, " locked at strobe"}, 32'(mon_if.locked_o), 32'(exp_locked_pre));
    tick();
    check_eq({tag, " strobe width"}, 32'(mon_if.count_valid_o), 0);
    check_flags(tag, exp_fast, exp_slow, exp_locked);
  endtask

  // stimulus
  initial begin
    // Reset held with fdiv toggling
    rst_n = 1'b0;
    repeat (5) tick();
    check_eq("rst count", 32'(mon_if.count_o), 0);
    check_eq("rst valid", 32'(mon_if.count_valid_o), 0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check_eq("rst state", 32'(dbg_state), 32'(IDLE));

    // Release; first strobe in cycle 103
    rst_n = 1'b1;
    wait_valid(250, lat);
    check_eq("first latency", lat, 103);
    check_range("first count", 32'(mon_if.count_o), 19, 21);
    check_eq("first state", 32'(dbg_state), 32'(EVALUATE));
    tick();
    check_flags("w1", 1'b0, 1'b0, 1'b0);

    // Nominal: lock after the 4th good window
    run_window("w2", 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("w3", 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("w4", 19, 21, 1'b0, 1'b0, 1'b0, 1'b1);

    // Drop lock with a slow window
    fdiv_period = 6;
    run_window("bad1", 14, 18, 1'b0, 1'b1, 1'b1,
`ifdef LOCK_MON_HYST_EN
               1'b1);
    run_window("bad2", 15, 18, 1'b0, 1'b1, 1'b1, 1'b0);
`else
               1'b0);
`endif

    // Relock after 4 more good windows
    fdiv_period = 5;
    run_window("g1", 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("g2", 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("g3", 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);
    run_window("g4", 19, 21, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-window reset at gate cycle 50
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid rst count", 32'(mon_if.count_o), 0);
    check_eq("mid rst valid", 32'(mon_if.count_valid_o), 0);
    check_flags("mid rst", 1'b0, 1'b0, 1'b0);
    check_eq("mid rst state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    wait_valid(250, lat);
    check_eq("mid rst latency", lat, 103);
    check_range("mid rst count after", 32'(mon_if.count_o), 19, 21);
    tick();
    check_flags("mid rst w1", 1'b0, 1'b0, 1'b0);

    // Fast: period 4
    fdiv_period = 4;
    run_window("fast1", 22, 27, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("fast2", 25, 26, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stuck high
    fdiv_hold   = 1'b1;
    fdiv_period = 0;
    run_window("stuck1", 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_window("stuck2", 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back to nominal: flags clear on the next good window
    fdiv_period = 5;
    run_window("recover1", 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
